// File: rtl/run_event_recorder_if.sv
// run_event_recorder_if: run-detect inputs and the record stream of run_event_recorder.
// rec_data widens by TS_W when RUN_TIMESTAMP_EN is defined.
interface run_event_recorder_if #(
   parameter int LEN_W = 8,
   parameter int CNT_W = 16,
   parameter int TS_W  = 16
);
`ifdef RUN_TIMESTAMP_EN
   localparam int RW = TS_W + LEN_W + 1;
`else
   localparam int RW = LEN_W + 1;
`endif
   logic             z;
   logic [3:0]       y;
   logic             rec_ready;
   logic             clr_ovf;
   logic             rec_valid;
   logic [RW-1:0]    rec_data;
   logic             ovf;
   logic [CNT_W-1:0] evt_cnt;
   modport master (
      input  z, y, rec_ready, clr_ovf,
      output rec_valid, rec_data, ovf, evt_cnt
   );
   modport slave (
      output z, y, rec_ready, clr_ovf,
      input  rec_valid, rec_data, ovf, evt_cnt
   );
endinterface

// File: rtl/run_event_recorder.sv
// run_event_recorder: measures z-high runs and queues {[ts,] pol, len} records in a show-ahead FIFO.
// Optional RUN_TIMESTAMP_EN adds a free-running timestamp captured at each run's first z=1 sample.
module run_event_recorder #(
   parameter int LEN_W = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16,
   parameter int TS_W  = 16
) (
   input  logic                clk,
   input  logic                aclr,
   run_event_recorder_if.master bus
);
   localparam int AW = $clog2(DEPTH);
`ifdef RUN_TIMESTAMP_EN
   localparam int RW = TS_W + LEN_W + 1;
`else
   localparam int RW = LEN_W + 1;
`endif
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_COMMIT} state_t;
   state_t           r_state, w_state_nxt;
   logic             r_z_q, r_pol_q, r_pol, r_ovf;
   logic [LEN_W-1:0] r_len;
   logic [CNT_W-1:0] r_evt_cnt;
   logic [RW-1:0]    r_mem [DEPTH];
   logic [AW:0]      r_wp, r_rp;
   logic             w_start, w_push, w_pop, w_full, w_empty, w_wr, w_drop;
   logic [RW-1:0]    w_rec;
`ifdef RUN_TIMESTAMP_EN
   logic [TS_W-1:0]  r_tsc, r_ts_q, r_ts;
   assign w_rec = {r_ts, r_pol, r_len};
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         r_tsc  <= '0;
         r_ts_q <= '0;
         r_ts   <= '0;
      end else begin
         r_tsc  <= r_tsc + 1'b1;
         r_ts_q <= r_tsc;
         if (w_start) r_ts <= r_ts_q;
      end
   end
`else
   assign w_rec = {r_pol, r_len};
`endif
   // polarity is delayed alongside z so each run's pol comes from its own first sample
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         r_z_q   <= 1'b0;
         r_pol_q <= 1'b0;
      end else begin
         r_z_q   <= bus.z;
         r_pol_q <= bus.y[3];
      end
   end
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_start     = r_z_q;
            w_state_nxt = r_z_q ? S_RUN : S_IDLE;
         end
         S_RUN: w_state_nxt = r_z_q ? S_RUN : S_COMMIT;
         S_COMMIT: begin
            w_push      = 1'b1;
            w_start     = r_z_q;
            w_state_nxt = r_z_q ? S_RUN : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         r_len <= '0;
         r_pol <= 1'b0;
      end else if (w_start) begin
         r_len <= LEN_W'(1);
         r_pol <= r_pol_q;
      end else if (r_state == S_RUN && r_z_q && r_len != '1) begin
         r_len <= r_len + 1'b1;
      end
   end
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign w_empty       = r_wp == r_rp;
   assign w_full        = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
   assign w_pop         = !w_empty && bus.rec_ready;
   assign w_wr          = w_push && (!w_full || w_pop);
   assign w_drop        = w_push && w_full && !w_pop;
   assign bus.rec_valid = !w_empty;
   assign bus.rec_data  = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
   assign bus.ovf       = r_ovf;
   assign bus.evt_cnt   = r_evt_cnt;
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp[AW-1:0]] <= w_rec;
   end
   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         r_wp      <= '0;
         r_rp      <= '0;
         r_ovf     <= 1'b0;
         r_evt_cnt <= '0;
      end else begin
         r_wp  <= r_wp + (AW+1)'(w_wr);
         r_rp  <= r_rp + (AW+1)'(w_pop);
         r_ovf <= w_drop || (r_ovf && !bus.clr_ovf);
         if (w_push && r_evt_cnt != '1) r_evt_cnt <= r_evt_cnt + 1'b1;
      end
   end
endmodule
